// File: rtl/serial_cmpr.sv
// Digit-serial magnitude comparator: walks two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, and stops at the first digit that differs.

module serial_cmpr_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    input  logic             flip_msb,
    output logic             lt,
    output logic             gt
);
    logic [DIGIT-1:0] xa, xb;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        xa = da;
        xb = db;
        if (flip_msb) begin
            xa[DIGIT-1] = ~da[DIGIT-1];
            xb[DIGIT-1] = ~db[DIGIT-1];
        end
        lt = (xa < xb);
        gt = (xa > xb);
    end
endmodule

module serial_cmpr #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             alessb,
    output logic             aequalb,
    output logic             agreaterb
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_FIRST = CW'(NDIG);
    localparam logic [CW-1:0] CNT_LAST  = CW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic             first, last, dig_lt, dig_gt, decide, accept;

    assign first  = (cnt == CNT_FIRST);
    assign last   = (cnt == CNT_LAST);
    assign accept = start && (state != CMP);

    serial_cmpr_digit #(.DIGIT(DIGIT)) u_digit (
        .da       (sh_a[WIDTH-1 -: DIGIT]),
        .db       (sh_b[WIDTH-1 -: DIGIT]),
        .flip_msb (first && mode),
        .lt       (dig_lt),
        .gt       (dig_gt)
    );

    assign decide = (state == CMP) && (dig_lt || dig_gt || last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CMP;
            CMP: begin
                busy = 1'b1;
                if (decide) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? CMP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result flags are written only on the deciding edge and otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a      <= '0;
            sh_b      <= '0;
            mode      <= 1'b0;
            cnt       <= '0;
            alessb    <= 1'b0;
            aequalb   <= 1'b0;
            agreaterb <= 1'b0;
        end else if (accept) begin
            sh_a <= a;
            sh_b <= b;
            mode <= signed_mode;
            cnt  <= CNT_FIRST;
        end else if (state == CMP) begin
            if (decide) begin
                alessb    <= dig_lt;
                agreaterb <= dig_gt;
                aequalb   <= !dig_lt && !dig_gt;
            end else begin
                sh_a <= sh_a << DIGIT;
                sh_b <= sh_b << DIGIT;
                cnt  <= cnt - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_serial_cmpr.sv
// Scoreboarded bench for serial_cmpr at three geometries: 16/4, 4/1 and 16/16.
module tb_serial_cmpr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  res;   // {lt, eq, gt}
        int unsigned dcyc;  // cycle count at which done must be seen
    } exp_t;

    exp_t q0[$], q1[$], q2[$];

    logic [2:0]  st, sm, bz, dn, lt, eq, gt;
    logic [15:0] a [3];
    logic [15:0] b [3];

    initial begin
        st = '0; sm = '0;
        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
    end

    serial_cmpr #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm[0]),
        .a(a[0]), .b(b[0]), .busy(bz[0]), .done(dn[0]),
        .alessb(lt[0]), .aequalb(eq[0]), .agreaterb(gt[0]));

    serial_cmpr #(.WIDTH(4), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm[1]),
        .a(a[1][3:0]), .b(b[1][3:0]), .busy(bz[1]), .done(dn[1]),
        .alessb(lt[1]), .aequalb(eq[1]), .agreaterb(gt[1]));

    serial_cmpr #(.WIDTH(16), .DIGIT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm[2]),
        .a(a[2]), .b(b[2]), .busy(bz[2]), .done(dn[2]),
        .alessb(lt[2]), .aequalb(eq[2]), .agreaterb(gt[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pop(input int id, output exp_t e);
        e.res = '0; e.dcyc = 0;
        case (id)
            0: if (q0.size() != 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Behavioural reference: plain integer compare after sign extension.
    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input int w, input bit s);
        longint sx, sy;
        sx = longint'(x) - ((s && x[w-1]) ? (longint'(1) << w) : 64'sd0);
        sy = longint'(y) - ((s && y[w-1]) ? (longint'(1) << w) : 64'sd0);
        return {sx < sy, sx == sy, sx > sy};
    endfunction

    function automatic int first_diff(input logic [15:0] x, input logic [15:0] y,
                                      input int w, input int d);
        int unsigned diff;
        diff = 32'(x ^ y);
        for (int k = 1; k <= w / d; k++)
            if (((diff >> (w - k * d)) & ((32'd1 << d) - 1)) != 0) return k;
        return w / d;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    if (!pop(i, e)) chk($sformatf("unexpected_done%0d", i), dn[i], 1'b0);
                    else begin
                        chk($sformatf("result%0d", i), {lt[i], eq[i], gt[i]}, e.res);
                        chk($sformatf("latency%0d", i), cyc, e.dcyc);
                        chk($sformatf("busy_in_done%0d", i), bz[i], 1'b0);
                    end
                end
            end
        end
    end

    // Called at a negedge; start is sampled on the following rising edge (E0).
    task automatic issue(input int id, input logic [15:0] x, input logic [15:0] y,
                         input bit s, input logic [2:0] res, input int k);
        exp_t e;
        e.res  = res;
        e.dcyc = cyc + 1 + k;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        st[id] = 1'b1; sm[id] = s; a[id] = x; b[id] = y;
        @(posedge clk);
        #1 st[id] = 1'b0;
    endtask

    task automatic wait_done(input int id);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dn[id]) return;
        end
        chk($sformatf("timeout%0d", id), dn[id], 1'b1);
    endtask

    localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;

    initial begin
        logic [15:0] x, y;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state%0d", i), {bz[i], dn[i], lt[i], eq[i], gt[i]}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-length compare with busy/done timing.
        issue(0, 16'h1234, 16'h1235, 1'b0, LT, 4);
        chk("busy_e0", bz[0], 1'b1);
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            #1 chk("busy_cmp", {bz[0], dn[0]}, 2'b10);
        end
        @(posedge clk);
        #1 chk("done_e4", {bz[0], dn[0], lt[0], eq[0], gt[0]}, 5'b01100);
        @(posedge clk);
        #1 chk("done_one_cycle", dn[0], 1'b0);
        @(negedge clk);

        // Early exit, unsigned then signed; old result held through CMP.
        issue(0, 16'h8000, 16'h0001, 1'b0, GT, 1);
        chk("hold_in_cmp", {lt[0], eq[0], gt[0]}, LT);
        wait_done(0);
        issue(0, 16'h8000, 16'h0001, 1'b1, LT, 1);
        wait_done(0);

        // Equal operands, then a back-to-back accept during DONE.
        issue(0, 16'hBEEF, 16'hBEEF, 1'b1, EQ, 4);
        wait_done(0);
        issue(0, 16'h0000, 16'hFFFF, 1'b0, LT, 1);
        wait_done(0);

        // start and operand changes while busy must be ignored.
        issue(0, 16'h1230, 16'h1234, 1'b0, LT, 4);
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b1; sm[0] = 1'b1; a[0] = 16'hFFFF; b[0] = 16'h0000;
        @(posedge clk);
        #1 st[0] = 1'b0;
        wait_done(0);
        repeat (5) @(negedge clk);

        // Asynchronous reset between E2 and E3 aborts without a done pulse.
        issue(0, 16'h1230, 16'h1234, 1'b0, LT, 4);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {bz[0], dn[0], lt[0], eq[0], gt[0]}, 5'b0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 16'h00F0, 16'h00E0, 1'b0, GT, 3);
        wait_done(0);

        // Single-digit geometry: done two edges after start.
        issue(2, 16'h8000, 16'h0001, 1'b1, LT, 1);
        wait_done(2);
        issue(2, 16'h7FFF, 16'h8000, 1'b1, GT, 1);
        wait_done(2);
        issue(2, 16'hFFFF, 16'hFFFF, 1'b0, EQ, 1);
        wait_done(2);
        issue(1, 16'h0008, 16'h0007, 1'b1, LT, 1);
        wait_done(1);

        // Exhaustive 4-bit sweep.
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    x = 16'(i); y = 16'(j);
                    issue(1, x, y, m[0], model(x, y, 4, m[0]), first_diff(x, y, 4, 1));
                    wait_done(1);
                end

        // Random pairs; every fourth differs in a single bit to reach deep digits.
        for (int id = 0; id < 3; id += 2)
            for (int j = 0; j < 1000; j++) begin
                bit s;
                int dg;
                dg = (id == 0) ? 4 : 16;
                x  = 16'($urandom);
                y  = (j % 4 == 0) ? (x ^ (16'd1 << $urandom_range(15))) :
                     (j % 17 == 0) ? x : 16'($urandom);
                s  = 1'($urandom);
                issue(id, x, y, s, model(x, y, 16, s), first_diff(x, y, 16, dg));
                wait_done(id);
            end

        repeat (4) @(negedge clk);
        chk("queue_drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
